// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset defaults,
// instruction field positions and the fetch state encoding.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DRAIN,
    ST_HOLD
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid, with load and flush.
// Flush wins over load and leaves PC+4 untouched.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ready handshake, one-entry skid buffer for
// words returning under a decode stall, and the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending;
  logic [31:0]  r_skid;
  logic         r_req;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_plus4;
  logic         w_ifid_load;
  logic         w_ifid_flush;
  logic [31:0]  w_ifid_data;
  logic [31:0]  w_ifid_instr;
  logic [31:0]  w_ifid_pc_plus4;
  logic         w_ifid_valid;

  always_comb begin
    w_redirect   = branch_taken | jump;
    w_target     = branch_taken ? word_align(branch_target)
                                : {w_ifid_pc_plus4[31:28], jump_index, 2'b00};
    w_pc_plus4   = r_pc + 32'd4;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    w_ifid_data  = imem_rdata;
    case (r_state)
      ST_FETCH: begin
        w_ifid_flush = w_redirect;
        w_ifid_load  = !w_redirect && imem_ready && !stall;
      end
      ST_DRAIN: w_ifid_flush = w_redirect;
      ST_HOLD: begin
        w_ifid_flush = w_redirect;
        w_ifid_load  = !w_redirect && !stall;
        w_ifid_data  = r_skid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT;
      r_pc      <= word_align(RESET_PC);
      r_pending <= '0;
      r_skid    <= '0;
      r_req     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (w_redirect) begin
            if (imem_ready) begin
              r_pc <= w_target;
            end else begin
              r_pending <= w_target;
              r_state   <= ST_DRAIN;
            end
          end else if (imem_ready) begin
            if (stall) begin
              r_skid  <= imem_rdata;
              r_state <= ST_HOLD;
              r_req   <= 1'b0;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        // The in-flight request must complete before the new PC is issued;
        // a redirect arriving together with ready is the latest and wins.
        ST_DRAIN: begin
          if (imem_ready) begin
            r_pc    <= w_redirect ? w_target : r_pending;
            r_state <= ST_FETCH;
          end else if (w_redirect) begin
            r_pending <= w_target;
          end
        end
        ST_HOLD: begin
          if (w_redirect) begin
            r_skid  <= '0;
            r_pc    <= w_target;
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end else if (!stall) begin
            r_pc    <= w_pc_plus4;
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_ifid_load),
    .i_flush   (w_ifid_flush),
    .i_instr   (w_ifid_data),
    .i_pc_plus4(w_pc_plus4),
    .o_instr   (w_ifid_instr),
    .o_pc_plus4(w_ifid_pc_plus4),
    .o_valid   (w_ifid_valid)
  );

  assign imem_req       = r_req;
  assign imem_addr      = r_pc;
  assign if_id_instr    = w_ifid_instr;
  assign if_id_pc_plus4 = w_ifid_pc_plus4;
  assign if_id_valid    = w_ifid_valid;
  assign opcode         = w_ifid_instr[OPCODE_MSB:OPCODE_LSB];

endmodule
